multicycle_sequencer: RTL and testbench

Multi-cycle FSM that sequences the RV32I datapath driven by the combinational `control` decoder. It steps each instruction through fetch, decode, execute, memory and writeback. It owns the memory request/ready handshake and gates the decoder's `enable_write` and PC update to the correct cycle. It also traps on illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/rv_ctrl_pkg.sv | 57 +++++
 rtl/mem_wait_timer.sv | 27 ++
 rtl/multicycle_sequencer.sv | 115 +++++++++++
 tb/tb_multicycle_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
// Holds the sequencer state encoding, the nine base opcodes, trap causes,
// the opcode-class type and a classifier used in DECODE.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6,
    S_UNUSED    = 3'd7
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_FETCH_TO = 2'd2,
    CAUSE_DATA_TO  = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_UPPER, CLS_ILLEGAL
  } opclass_e;

  // Memory-side request bundle driven by the sequencer.
  typedef struct packed {
    logic req;
    logic we;
    logic addr_sel;  // 0 = PC, 1 = ALU address
  } mem_ctl_t;

  function automatic opclass_e classify(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP_IMM: return CLS_ALU;
      OPC_LOAD:           return CLS_LOAD;
      OPC_STORE:          return CLS_STORE;
      OPC_BRANCH:         return CLS_BRANCH;
      OPC_JAL, OPC_JALR:  return CLS_JUMP;
      OPC_LUI, OPC_AUIPC: return CLS_UPPER;
      default:            return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for a pending memory request.
// Ports: clk, rst_n (async low), clr (zero the count), en (a wait cycle is
// in progress), timeout (this wait cycle is the TIMEOUT-th without ready).
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of already-elapsed wait cycles, so the current
  // cycle is wait number cnt+1.
  assign timeout = en && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (clr || timeout)  cnt <= '0;  // expiry leaves the state anyway
    else if (en)              cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FSM sequencing the RV32I datapath through fetch, decode,
// execute, memory and writeback; owns the memory handshake, traps on
// illegal opcodes and memory timeouts, and counts retired instructions.
// Ports: run/opcode/mem_ready/trap_clear in; mem_req, mem_we,
// pc_or_address, ir_write, pc_write, reg_write strobes; state, trap,
// trap_cause, instret status.
module multicycle_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  input  logic                 trap_clear,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 pc_or_address,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  state_e                st;
  opclass_e              cls;
  cause_e                cause_q;
  logic [INSTRET_W-1:0]  instret_q;
  opclass_e              dec_cls;
  logic                  waiting, timed_out, retire;
  mem_ctl_t              mem_ctl;

  assign dec_cls = classify(opcode);

  // A wait cycle is any request cycle without ready; everything else,
  // including every state change, clears the counter.
  assign waiting = (st == S_FETCH || st == S_MEM) && !mem_ready;

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!waiting),
    .en      (waiting),
    .timeout (timed_out)
  );

  assign retire = (st == S_EXECUTE && cls == CLS_BRANCH) ||
                  (st == S_MEM && cls == CLS_STORE && mem_ready) ||
                  (st == S_WRITEBACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      cls       <= CLS_ALU;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      case (st)
        S_IDLE: if (run) st <= S_FETCH;
        S_FETCH: begin
          if (mem_ready)      st <= S_DECODE;  // ready beats a same-cycle timeout
          else if (timed_out) begin st <= S_TRAP; cause_q <= CAUSE_FETCH_TO; end
        end
        S_DECODE: begin
          cls <= dec_cls;
          if (dec_cls == CLS_ILLEGAL) begin st <= S_TRAP; cause_q <= CAUSE_ILLEGAL; end
          else                         st <= S_EXECUTE;
        end
        S_EXECUTE: begin
          case (cls)
            CLS_LOAD, CLS_STORE: st <= S_MEM;
            CLS_BRANCH:          st <= S_FETCH;
            default:             st <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (mem_ready)      st <= (cls == CLS_STORE) ? S_FETCH : S_WRITEBACK;
          else if (timed_out) begin st <= S_TRAP; cause_q <= CAUSE_DATA_TO; end
        end
        S_WRITEBACK: st <= S_FETCH;
        S_TRAP: if (trap_clear) begin st <= S_IDLE; cause_q <= CAUSE_NONE; end
        S_UNUSED: st <= S_IDLE;
        default:  st <= S_IDLE;
      endcase
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  // Outputs decode from the registered state so an async reset drops them
  // immediately; ir_write and the store-completion pc_write follow ready.
  always_comb begin
    mem_ctl          = '0;
    mem_ctl.req      = (st == S_FETCH) || (st == S_MEM);
    mem_ctl.addr_sel = (st == S_MEM);
    mem_ctl.we       = (st == S_MEM) && (cls == CLS_STORE);
  end

  assign mem_req       = mem_ctl.req;
  assign mem_we        = mem_ctl.we;
  assign pc_or_address = mem_ctl.addr_sel;
  assign ir_write      = (st == S_FETCH) && mem_ready;
  assign pc_write      = retire;
  assign reg_write     = (st == S_WRITEBACK);
  assign state         = st;
  assign trap          = (st == S_TRAP);
  assign trap_cause    = cause_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: stimulus pushes the hand-derived expected output vector
// for each cycle; a monitor pops and compares at the falling edge.
module tb_multicycle_sequencer;

  localparam logic [2:0] I = 3'd0, F = 3'd1, D = 3'd2, E = 3'd3,
                         M = 3'd4, W = 3'd5, T = 3'd6;
  localparam logic [6:0] X      = 7'h7F;  // illegal filler outside DECODE
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n, run, mem_ready, trap_clear;
  logic [6:0] opcode;
  logic       mem_req, mem_we, pc_or_address, ir_write, pc_write, reg_write, trap;
  logic [2:0] state;
  logic [1:0] trap_cause;
  logic [3:0] instret;

  multicycle_sequencer #(.MEM_TIMEOUT(15), .INSTRET_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .mem_ready(mem_ready), .trap_clear(trap_clear),
    .mem_req(mem_req), .mem_we(mem_we), .pc_or_address(pc_or_address),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic req, we, pa, ir, pcw, rw, trp;
    logic [1:0] cause;
    logic [3:0] ic;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_chk = 0, n_fail = 0;

  function automatic exp_t ex(input logic [2:0] st, input logic req, input logic we,
                              input logic pa, input logic ir, input logic pcw,
                              input logic rw, input logic trp,
                              input logic [1:0] cause, input logic [3:0] ic);
    exp_t e;
    e = {st, req, we, pa, ir, pcw, rw, trp, cause, ic};
    return e;
  endfunction

  task automatic cyc(input string t, input logic r, input logic rdy,
                     input logic [6:0] op, input logic tc, input exp_t e);
    @(posedge clk); #1;
    run = r; mem_ready = rdy; opcode = op; trap_clear = tc;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Monitor
  exp_t  m_exp, m_act;
  string m_tag;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      m_act = {state, mem_req, mem_we, pc_or_address, ir_write, pc_write,
               reg_write, trap, trap_cause, instret};
      n_chk++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL %s: got st/req/we/pa/ir/pcw/rw/trap/cause/instret=%b expected %b",
                 m_tag, m_act, m_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = X; trap_clear = 1'b0;

    cyc("reset", 0, 0, X, 0, ex(I,0,0,0,0,0,0,0,0,0));
    #6 rst_n = 1'b1;
    cyc("idle_run", 1, 0, X, 0, ex(I,0,0,0,0,0,0,0,0,0));

    // OP, ready always 1: 1,2,3,5 then FETCH
    cyc("op_f", 0, 1, X,  0, ex(F,1,0,0,1,0,0,0,0,0));
    cyc("op_d", 0, 0, OP, 0, ex(D,0,0,0,0,0,0,0,0,0));
    cyc("op_e", 0, 0, X,  0, ex(E,0,0,0,0,0,0,0,0,0));
    cyc("op_w", 0, 0, X,  0, ex(W,0,0,0,0,1,1,0,0,0));

    // LOAD with 3 wait cycles in MEM
    cyc("ld_f", 0, 1, X,    0, ex(F,1,0,0,1,0,0,0,0,1));
    cyc("ld_d", 0, 0, LOAD, 0, ex(D,0,0,0,0,0,0,0,0,1));
    cyc("ld_e", 0, 0, X,    0, ex(E,0,0,0,0,0,0,0,0,1));
    for (int i = 0; i < 3; i++)
      cyc("ld_mwait", 0, 0, X, 0, ex(M,1,0,1,0,0,0,0,0,1));
    cyc("ld_mrdy", 0, 1, X, 0, ex(M,1,0,1,0,0,0,0,0,1));
    cyc("ld_w",    0, 0, X, 0, ex(W,0,0,0,0,1,1,0,0,1));

    // STORE then BRANCH
    cyc("st_f", 0, 1, X,     0, ex(F,1,0,0,1,0,0,0,0,2));
    cyc("st_d", 0, 0, STORE, 0, ex(D,0,0,0,0,0,0,0,0,2));
    cyc("st_e", 0, 0, X,     0, ex(E,0,0,0,0,0,0,0,0,2));
    cyc("st_m", 0, 1, X,     0, ex(M,1,1,1,0,1,0,0,0,2));
    cyc("br_f", 0, 1, X,      0, ex(F,1,0,0,1,0,0,0,0,3));
    cyc("br_d", 0, 0, BRANCH, 0, ex(D,0,0,0,0,0,0,0,0,3));
    cyc("br_e", 0, 0, X,      0, ex(E,0,0,0,0,1,0,0,0,3));

    // Illegal opcode trap and clear
    cyc("il_f",     0, 1, X,        0, ex(F,1,0,0,1,0,0,0,0,4));
    cyc("il_d",     0, 0, 7'h7F,    0, ex(D,0,0,0,0,0,0,0,0,4));
    cyc("il_trap",  0, 1, X,        0, ex(T,0,0,0,0,0,0,1,1,4));
    cyc("il_clr",   0, 0, X,        1, ex(T,0,0,0,0,0,0,1,1,4));
    cyc("clr_idle", 0, 0, X,        1, ex(I,0,0,0,0,0,0,0,0,4));
    cyc("idle_run", 1, 0, X,        0, ex(I,0,0,0,0,0,0,0,0,4));

    // Fetch timeout after 15 wait cycles
    for (int i = 0; i < 15; i++)
      cyc("fto_wait", 0, 0, X, 0, ex(F,1,0,0,0,0,0,0,0,4));
    cyc("fto_trap", 0, 0, X, 1, ex(T,0,0,0,0,0,0,1,2,4));
    cyc("idle_run", 1, 0, X, 0, ex(I,0,0,0,0,0,0,0,0,4));

    // Ready on the 15th wait cycle wins
    for (int i = 0; i < 14; i++)
      cyc("f15_wait", 0, 0, X, 0, ex(F,1,0,0,0,0,0,0,0,4));
    cyc("f15_rdy", 0, 1, X,   0, ex(F,1,0,0,1,0,0,0,0,4));
    cyc("jal_d",   0, 0, JAL, 0, ex(D,0,0,0,0,0,0,0,0,4));
    cyc("jal_e",   0, 0, X,   0, ex(E,0,0,0,0,0,0,0,0,4));
    cyc("jal_w",   0, 0, X,   0, ex(W,0,0,0,0,1,1,0,0,4));

    // Data timeout in MEM
    cyc("dto_f", 0, 1, X,    0, ex(F,1,0,0,1,0,0,0,0,5));
    cyc("dto_d", 0, 0, LOAD, 0, ex(D,0,0,0,0,0,0,0,0,5));
    cyc("dto_e", 0, 0, X,    0, ex(E,0,0,0,0,0,0,0,0,5));
    for (int i = 0; i < 15; i++)
      cyc("dto_wait", 0, 0, X, 0, ex(M,1,0,1,0,0,0,0,0,5));
    cyc("dto_trap", 0, 0, X, 1, ex(T,0,0,0,0,0,0,1,3,5));
    cyc("idle_run", 1, 0, X, 0, ex(I,0,0,0,0,0,0,0,0,5));

    // 12 branches: instret 5 -> wraps through 0 -> 1
    for (int i = 0; i < 12; i++) begin
      cyc("wrap_f", 0, 1, X,      0, ex(F,1,0,0,1,0,0,0,0,4'(5 + i)));
      cyc("wrap_d", 0, 0, BRANCH, 0, ex(D,0,0,0,0,0,0,0,0,4'(5 + i)));
      cyc("wrap_e", 0, 0, X,      0, ex(E,0,0,0,0,1,0,0,0,4'(5 + i)));
    end

    // Reset in the middle of a MEM wait, with ready arriving that cycle
    cyc("rm_f", 0, 1, X,    0, ex(F,1,0,0,1,0,0,0,0,1));
    cyc("rm_d", 0, 0, LOAD, 0, ex(D,0,0,0,0,0,0,0,0,1));
    cyc("rm_e", 0, 0, X,    0, ex(E,0,0,0,0,0,0,0,0,1));
    cyc("rm_m", 0, 0, X,    0, ex(M,1,0,1,0,0,0,0,0,1));
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    exp_q.push_back(ex(I,0,0,0,0,0,0,0,0,0));
    tag_q.push_back("rst_async");
    cyc("rst_hold", 0, 1, X, 0, ex(I,0,0,0,0,0,0,0,0,0));
    #6 rst_n = 1'b1;
    cyc("post_rst", 0, 0, X, 0, ex(I,0,0,0,0,0,0,0,0,0));

    @(negedge clk); #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
